// File: rtl/axi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_pkg: AXI burst/response encodings, responder states, wrap mask   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_e;

  localparam logic [1:0] c_resp_okay   = 2'd0;
  localparam logic [1:0] c_resp_slverr = 2'd2;
  localparam logic [1:0] c_resp_decerr = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LATENCY = 2'd1,
    ST_BURST   = 2'd2
  } rsp_state_e;

  // Clears the offset bits within a (len+1)*(1<<size) byte wrap window.
  function automatic logic [63:0] wrap_mask(input logic [7:0] len, input logic [2:0] size);
    logic [63:0] total;
    total = ({56'd0, len} + 64'd1) << size;
    return ~(total - 64'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_burst_addr_gen: next beat byte address for FIXED/INCR/WRAP       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  input  burst_e                burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [63:0]           w_mask_full;
  logic [ADDR_WIDTH-1:0] w_mask;
  logic [ADDR_WIDTH-1:0] w_nbytes;
  logic [ADDR_WIDTH-1:0] w_incr;
  logic [ADDR_WIDTH-1:0] w_low;
  logic [ADDR_WIDTH-1:0] w_high;

  assign w_mask_full = wrap_mask(len, size);
  assign w_mask      = w_mask_full[ADDR_WIDTH-1:0];
  assign w_nbytes    = ADDR_WIDTH'(1) << size;
  assign w_incr      = addr + w_nbytes;
  assign w_low       = addr & w_mask;
  // One past the top of the wrap window: low + total.
  assign w_high      = w_low + ~w_mask + ADDR_WIDTH'(1);

  always_comb begin
    next_addr = w_incr;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (w_incr == w_high) ? w_low : w_incr;
      default:     next_addr = w_incr;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/axi_read_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_read_responder: AXI4 AR/R slave over a preloadable word memory.  |
// | Optional AXI_RESP_ID_EN adds arid/rid. Rev 1.0                       |
// +----------------------------------------------------------------------+
module axi_read_responder
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int MEM_WORDS    = 4096,
  parameter int READ_LATENCY = 2
`ifdef AXI_RESP_ID_EN
  , parameter int ID_WIDTH   = 4
`endif
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
  input  logic [7:0]                   s_axi_arlen,
  input  logic [2:0]                   s_axi_arsize,
  input  logic [1:0]                   s_axi_arburst,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  output logic [DATA_WIDTH-1:0]        s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rlast,
  input  logic                         load_en,
  input  logic [$clog2(MEM_WORDS)-1:0] load_index,
  input  logic [DATA_WIDTH-1:0]        load_data
`ifdef AXI_RESP_ID_EN
  , input  logic [ID_WIDTH-1:0]        s_axi_arid
  , output logic [ID_WIDTH-1:0]        s_axi_rid
`endif
);

  localparam int c_byte_shift = $clog2(DATA_WIDTH / 8);
  localparam int c_idx_w      = $clog2(MEM_WORDS);
  localparam logic [1:0] c_st_idle    = ST_IDLE;
  localparam logic [1:0] c_st_latency = ST_LATENCY;
  localparam logic [1:0] c_st_burst   = ST_BURST;

  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  logic [1:0]            r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_next_addr, w_beat_addr, w_word_full;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  burst_e                r_burst, w_burst_eff;
  logic                  r_slverr, w_slverr;
  logic [8:0]            r_beat, w_beat_idx;
  logic [3:0]            r_lat;
  logic                  r_arready, r_rvalid, r_rlast;
  logic [DATA_WIDTH-1:0] r_rdata, w_beat_data;
  logic [1:0]            r_rresp, w_beat_resp;
  logic                  w_ar_hs, w_r_hs, w_beat_load, w_oor, w_wrap_len_ok;

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .addr      (r_addr),
    .size      (r_size),
    .len       (r_len),
    .burst     (r_burst),
    .next_addr (w_next_addr)
  );

  assign w_ar_hs       = s_axi_arvalid & r_arready;
  assign w_r_hs        = r_rvalid & s_axi_rready;
  assign w_wrap_len_ok = (s_axi_arlen == 8'd1) || (s_axi_arlen == 8'd3) ||
                         (s_axi_arlen == 8'd7) || (s_axi_arlen == 8'd15);

  // Reserved bursts and illegal wrap lengths still walk addresses as INCR.
  always_comb begin
    w_burst_eff = BURST_INCR;
    w_slverr    = (s_axi_arsize > 3'(c_byte_shift));
    case (s_axi_arburst)
      2'd0: w_burst_eff = BURST_FIXED;
      2'd1: w_burst_eff = BURST_INCR;
      2'd2: begin
        w_burst_eff = w_wrap_len_ok ? BURST_WRAP : BURST_INCR;
        if (!w_wrap_len_ok) w_slverr = 1'b1;
      end
      default: w_slverr = 1'b1;
    endcase
  end

  assign w_beat_load = ((r_state == c_st_latency) && (r_lat == 4'd0)) ||
                       ((r_state == c_st_burst) && w_r_hs && !r_rlast);
  assign w_beat_addr = (r_state == c_st_burst) ? w_next_addr : r_addr;
  assign w_beat_idx  = (r_state == c_st_burst) ? (r_beat + 9'd1) : 9'd0;
  assign w_word_full = w_beat_addr >> c_byte_shift;
  assign w_oor       = (w_word_full >= ADDR_WIDTH'(MEM_WORDS));
  assign w_beat_data = w_oor ? '0 : r_mem[w_word_full[c_idx_w-1:0]];
  assign w_beat_resp = r_slverr ? c_resp_slverr : (w_oor ? c_resp_decerr : c_resp_okay);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:    if (w_ar_hs) w_state_nxt = c_st_latency;
      c_st_latency: if (r_lat == 4'd0) w_state_nxt = c_st_burst;
      c_st_burst:   if (w_r_hs && r_rlast) w_state_nxt = c_st_idle;
      default:      w_state_nxt = c_st_idle;
    endcase
  end

  // Memory is never reset; a beat registered alongside a load sees the old word.
  always_ff @(posedge clock) begin
    if (load_en) r_mem[load_index] <= load_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= c_st_idle;
      r_arready <= 1'b0;
      r_addr    <= '0;
      r_len     <= 8'd0;
      r_size    <= 3'd0;
      r_burst   <= BURST_INCR;
      r_slverr  <= 1'b0;
      r_beat    <= 9'd0;
      r_lat     <= 4'd0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= c_resp_okay;
    end else begin
      r_state   <= w_state_nxt;
      r_arready <= (w_state_nxt == c_st_idle);
      if (w_ar_hs) begin
        r_addr   <= s_axi_araddr;
        r_len    <= s_axi_arlen;
        r_size   <= s_axi_arsize;
        r_burst  <= w_burst_eff;
        r_slverr <= w_slverr;
        r_lat    <= 4'(READ_LATENCY - 1);
      end else if ((r_state == c_st_latency) && (r_lat != 4'd0)) begin
        r_lat <= r_lat - 4'd1;
      end
      if (w_beat_load) begin
        r_addr   <= w_beat_addr;
        r_beat   <= w_beat_idx;
        r_rvalid <= 1'b1;
        r_rdata  <= w_beat_data;
        r_rresp  <= w_beat_resp;
        r_rlast  <= (w_beat_idx == {1'b0, r_len});
      end else if ((r_state == c_st_burst) && w_r_hs && r_rlast) begin
        r_rvalid <= 1'b0;
        r_rlast  <= 1'b0;
      end
    end
  end

`ifdef AXI_RESP_ID_EN
  logic [ID_WIDTH-1:0] r_rid;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       r_rid <= '0;
    else if (w_ar_hs) r_rid <= s_axi_arid;
  end
  assign s_axi_rid = r_rid;
`endif

  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rlast   = r_rlast;

endmodule
`default_nettype wire

// File: doc/axi_read_responder.md
Name: axi_read_responder

Overview:
- AXI4 read-channel slave (AR/R) that answers burst reads from the cache's line-fill engine, which is the AXI read master.
- Backed by a word-addressed memory array of DATA_WIDTH-bit words, preloaded through a simple load port.
- Serves as the memory-side model for cache integration benches and as the template for the future real memory controller front-end.
- One outstanding burst at a time; supports FIXED, INCR and WRAP bursts with a programmable first-beat latency.

Parameters:
- ADDR_WIDTH, 64, AXI address width.
- DATA_WIDTH, 64, rdata width; bytes per beat = DATA_WIDTH/8.
- MEM_WORDS, 4096, depth of the backing array in DATA_WIDTH words.
- READ_LATENCY, 2, cycles from AR handshake to first rvalid; legal range 1..15.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address ready.
- s_axi_araddr  in  ADDR_WIDTH  burst start byte address.
- s_axi_arlen  in  8  beats minus 1.
- s_axi_arsize  in  3  log2 bytes per beat.
- s_axi_arburst  in  2  0=FIXED, 1=INCR, 2=WRAP, 3=reserved.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  master ready for data.
- s_axi_rdata  out  DATA_WIDTH  beat data.
- s_axi_rresp  out  2  0=OKAY, 2=SLVERR, 3=DECERR.
- s_axi_rlast  out  1  final beat of burst.
- load_en  in  1  preload write strobe.
- load_index  in  $clog2(MEM_WORDS)  preload word index.
- load_data  in  DATA_WIDTH  preload word.

Behaviour:
- Reset (asynchronous, reset==0):
  - Outputs: arready=0, rvalid=0, rlast=0, rresp=0, rdata=0.
  - State goes to IDLE; counters are cleared; memory contents are not cleared.
  - A reset asserted mid-burst abandons the burst immediately.
  - arready rises the first cycle after reset deasserts.
- IDLE:
  - arready=1.
  - On arvalid&&arready: latch addr, len, size and burst; compute the WRAP boundary; load the latency counter with READ_LATENCY-1; go to LATENCY. arready drops the next cycle.
- LATENCY:
  - arready=0; count down.
  - At 0, register beat 0 (rdata/rresp/rlast) and go to BURST, with rvalid=1.
  - An AR handshake at edge T gives first rvalid high during cycle T+READ_LATENCY.
- BURST:
  - rvalid=1. While rready=0, rdata, rresp and rlast stay stable.
  - On rvalid&&rready with !rlast: compute the next address and present the next beat in the following cycle. This gives back-to-back beats with no bubble while rready is held high.
  - On rvalid&&rready with rlast: rvalid=0 and rlast=0 the next cycle, then IDLE. arready=1 in that same next cycle.
- Beat count:
  - Exactly arlen+1 beats; rlast=1 only on beat index arlen.
  - A 9-bit beat counter avoids overflow at arlen=255.
- Address generation (byte address, nbytes=1<<arsize):
  - FIXED: address unchanged.
  - INCR: addr+nbytes.
  - WRAP: total=(arlen+1)*nbytes, low=addr & ~(total-1); next=addr+nbytes, and if next==low+total then next=low.
  - WRAP with arlen not in {1,3,7,15} is treated as INCR with rresp=SLVERR on all beats.
- Data lookup:
  - word index = addr >> log2(DATA_WIDTH/8).
  - The full aligned word is returned; the master selects lanes for narrow sizes.
- Responses:
  - Index >= MEM_WORDS: rdata=0, rresp=DECERR for that beat only; the burst continues.
  - arsize > log2(DATA_WIDTH/8): SLVERR on every beat.
  - arburst=3: SLVERR on every beat, addressing treated as INCR.
- Load port:
  - Writes the memory on the clock edge in any state.
  - An already-registered rdata is not altered. A beat registered in the same edge as a load to the same word returns the old value.
- arvalid during LATENCY or BURST is ignored (arready=0); the master holds it.

Optional Feature:
- AXI_RESP_ID_EN defined:
  - Adds parameter ID_WIDTH (default 4), input s_axi_arid[ID_WIDTH] and output s_axi_rid[ID_WIDTH].
  - arid is latched at AR handshake and driven on rid for every beat of that burst.
  - rid resets to 0.
- Not defined: no ID ports; behaviour otherwise identical.

Decomposition:
- Package axi_pkg:
  - Burst type enum (FIXED/INCR/WRAP) and resp code constants (OKAY/SLVERR/DECERR).
  - Responder state enum (IDLE/LATENCY/BURST).
  - Function computing the WRAP boundary mask.
- Sub-module axi_burst_addr_gen: combinational next-address and wrap logic from (addr, size, len, burst). Reusable later by the write responder.

Test Plan:
- Preload word i with value 64'hA000_0000_0000_0000+i. AR addr=0x40, len=7, size=3, INCR, rready=1 -> first rvalid 2 cycles after handshake. 8 consecutive beats with data A..08 through A..0F, rlast on beat 7, rresp=0 throughout.
- WRAP burst, addr=0x58, len=7, size=3 -> beats are words 0B,0C,0D,0E,0F,08,09,0A; rlast on the 8th beat.
- Same INCR burst with rready toggled 1,0,0,1,... -> rdata and rlast held stable while rready=0; exactly 8 beats accepted; arready=0 until the cycle after the last handshake.
- AR addr=(MEM_WORDS-2)*8, len=3, INCR -> beats 0 and 1 OKAY with preloaded data; beats 2 and 3 rdata=0, rresp=3.
- AR with size=4, len=1 -> 2 beats, both rresp=2. AR with arburst=3 -> all beats rresp=2.
- Assert reset low during beat 3 of a len=7 burst -> rvalid=0 and rlast=0 immediately (asynchronous). After release, arready=1 the next cycle, and a new burst returns correct data from index 0.
